// File: rtl/ecp5pll_phase_sequencer.sv
// ecp5pll_phase_sequencer: EHXPLLL reset/lock supervisor with per-output dynamic phase stepping
module ecp5pll_phase_sequencer #(
    parameter int CHANNELS     = 4,
    parameter int PHASE_MOD    = 32,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_FILTER  = 1024,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int SETUP_CYCLES = 2,
    parameter int STEP_CYCLES  = 4,
    localparam int PHASE_W     = $clog2(PHASE_MOD)
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        pll_lock,
    output logic                        pll_rst,
    output logic [1:0]                  pll_phasesel,
    output logic                        pll_phasedir,
    output logic                        pll_phasestep,
    output logic                        locked,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [1:0]                  req_chan,
    input  logic                        req_dir,
    input  logic [7:0]                  req_count,
    output logic [CHANNELS*PHASE_W-1:0] phase,
    output logic [7:0]                  retries
);
    typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, IDLE, SETUP, STEP_HI, STEP_LO} state_t;

    localparam int FW = $clog2(LOCK_FILTER + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [15:0]        RST_LAST   = 16'(RST_CYCLES - 1);
    localparam logic [15:0]        SETUP_LAST = 16'(SETUP_CYCLES - 1);
    localparam logic [15:0]        STEP_LAST  = 16'(STEP_CYCLES - 1);
    localparam logic [FW-1:0]      FILT_LAST  = FW'(LOCK_FILTER - 1);
    localparam logic [TW-1:0]      TMO_LAST   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [PHASE_W-1:0] PHASE_MAX  = PHASE_W'(PHASE_MOD - 1);
    localparam logic [2:0]         NCHAN      = 3'(CHANNELS);

    state_t                           r_state, w_next;
    logic [1:0]                       r_sync;
    logic [15:0]                      r_cnt;
    logic [FW-1:0]                    r_filt;
    logic [TW-1:0]                    r_tmo;
    logic [1:0]                       r_sel;
    logic                             r_dir;
    logic [7:0]                       r_left;
    logic [7:0]                       r_retries;
    logic [CHANNELS-1:0][PHASE_W-1:0] r_phase;
    logic                             w_lock_s;
    logic                             w_accept;
    logic                             w_step_done;

    assign w_lock_s    = r_sync[1];
    assign w_accept    = req_valid && req_count != 8'd0 && {1'b0, req_chan} < NCHAN;
    assign w_step_done = r_state == STEP_LO && r_cnt == STEP_LAST;

    assign pll_rst       = r_state == RESET_PLL;
    assign pll_phasestep = r_state == STEP_HI;
    assign req_ready     = r_state == IDLE;
    assign locked        = r_state != RESET_PLL && r_state != WAIT_LOCK;
    assign pll_phasesel  = r_sel;
    assign pll_phasedir  = r_dir;
    assign phase         = r_phase;
    assign retries       = r_retries;

    // two-flop synchronizer for the asynchronous PLL lock
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) r_sync <= 2'b00;
        else r_sync <= {r_sync[0], pll_lock};

    // state register
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) r_state <= RESET_PLL;
        else r_state <= w_next;

    // next state: lock loss anywhere past WAIT_LOCK restarts the PLL
    always_comb begin
        w_next = r_state;
        case (r_state)
            RESET_PLL: w_next = r_cnt == RST_LAST ? WAIT_LOCK : RESET_PLL;
            WAIT_LOCK: w_next = (w_lock_s && r_filt == FILT_LAST) ? IDLE :
                                (r_tmo == TMO_LAST) ? RESET_PLL : WAIT_LOCK;
            IDLE:      w_next = !w_lock_s ? RESET_PLL : (w_accept ? SETUP : IDLE);
            SETUP:     w_next = !w_lock_s ? RESET_PLL : (r_cnt == SETUP_LAST ? STEP_HI : SETUP);
            STEP_HI:   w_next = !w_lock_s ? RESET_PLL : (r_cnt == STEP_LAST ? STEP_LO : STEP_HI);
            STEP_LO:   w_next = !w_lock_s ? RESET_PLL : !w_step_done ? STEP_LO :
                                (r_left == 8'd1 ? IDLE : STEP_HI);
            default:   w_next = RESET_PLL;
        endcase
    end

    // per-state cycle counter, lock filter, timeout and saturating retry count
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            r_cnt     <= '0;
            r_filt    <= '0;
            r_tmo     <= '0;
            r_retries <= '0;
        end else begin
            r_cnt  <= w_next == r_state ? r_cnt + 16'd1 : 16'd0;
            r_filt <= (r_state == WAIT_LOCK && w_lock_s) ? r_filt + FW'(1) : '0;
            r_tmo  <= r_state == WAIT_LOCK ? r_tmo + TW'(1) : '0;
            if (r_state == WAIT_LOCK && w_next == RESET_PLL && r_retries != 8'hFF)
                r_retries <= r_retries + 8'd1;
        end

    // request latch and phase tracking; a PLL reset restores static phases
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            r_sel   <= '0;
            r_dir   <= 1'b0;
            r_left  <= '0;
            r_phase <= '0;
        end else begin
            if (r_state == IDLE && w_next == SETUP) begin
                r_sel  <= req_chan;
                r_dir  <= req_dir;
                r_left <= req_count;
            end
            if (w_next == RESET_PLL) r_phase <= '0;
            else if (w_step_done) begin
                r_left <= r_left - 8'd1;
                for (int n = 0; n < CHANNELS; n++)
                    if (r_sel == 2'(n))
                        r_phase[n] <= r_dir ?
                            (r_phase[n] == '0 ? PHASE_MAX : r_phase[n] - PHASE_W'(1)) :
                            (r_phase[n] == PHASE_MAX ? '0 : r_phase[n] + PHASE_W'(1));
            end
        end
endmodule

// File: tb/tb_ecp5pll_phase_sequencer.sv
// tb_ecp5pll_phase_sequencer: randomized self-checking bench against an arithmetic phase/timing model
module tb_ecp5pll_phase_sequencer;
    localparam int CH = 3, PM = 32, RC = 16, LF = 32, LT = 128, SC = 2, SS = 4;
    localparam int PW = $clog2(PM);

    logic             clk = 1'b0, rstn = 1'b0, pll_lock = 1'b0;
    logic             req_valid = 1'b0, req_dir = 1'b0;
    logic [1:0]       req_chan = 2'd0;
    logic [7:0]       req_count = 8'd0;
    logic             pll_rst, pll_phasedir, pll_phasestep, locked, req_ready;
    logic [1:0]       pll_phasesel;
    logic [CH*PW-1:0] phase;
    logic [7:0]       retries;

    int n_pass = 0, n_chk = 0;
    int m_phase [CH];
    int m_sel = 0, m_dir = 0, m_retries = 0;

    ecp5pll_phase_sequencer #(
        .CHANNELS(CH), .PHASE_MOD(PM), .RST_CYCLES(RC), .LOCK_FILTER(LF),
        .LOCK_TIMEOUT(LT), .SETUP_CYCLES(SC), .STEP_CYCLES(SS)
    ) dut (
        .clk(clk), .rstn(rstn), .pll_lock(pll_lock), .pll_rst(pll_rst),
        .pll_phasesel(pll_phasesel), .pll_phasedir(pll_phasedir), .pll_phasestep(pll_phasestep),
        .locked(locked), .req_valid(req_valid), .req_ready(req_ready), .req_chan(req_chan),
        .req_dir(req_dir), .req_count(req_count), .phase(phase), .retries(retries)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, int got, int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic logic sig(int w);
        return w == 0 ? pll_rst : w == 1 ? locked : w == 2 ? req_ready : pll_phasestep;
    endfunction

    task automatic wait_for(string tag, int w, logic v, int lim, output int n);
        n = 0;
        while (sig(w) !== v && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " reached"}, int'(sig(w) === v), 1);
    endtask

    task automatic chk_state(string tag);
        for (int c = 0; c < CH; c++)
            chk($sformatf("%s phase[%0d]", tag, c), int'(phase[c*PW +: PW]), m_phase[c]);
        chk({tag, " retries"}, int'(retries), m_retries);
    endtask

    task automatic do_req(int c, int d, int k);
        int  n, rises, hi, first, bad;
        bit  noop;
        logic prev;
        string tag;
        n = 0; rises = 0; hi = 0; first = -1; bad = 0; prev = 1'b0;
        noop = (k == 0) || (c >= CH);
        tag = $sformatf("req c%0d d%0d k%0d", c, d, k);
        req_valid = 1'b1; req_chan = 2'(c); req_dir = 1'(d); req_count = 8'(k);
        @(negedge clk);
        req_valid = 1'b0;
        while (!req_ready && n < SC + 2 * SS * 256 + 4) begin
            if (pll_phasesel != 2'(c) || pll_phasedir != 1'(d)) bad++;
            if (pll_phasestep) begin
                hi++;
                if (!prev) begin
                    rises++;
                    if (first < 0) first = n;
                end
            end
            prev = pll_phasestep;
            @(negedge clk);
            n++;
        end
        if (!noop) begin
            m_phase[c] = ((m_phase[c] + (d != 0 ? -k : k)) % PM + PM) % PM;
            m_sel = c;
            m_dir = d;
        end
        chk({tag, " latency"}, n + 1, noop ? 1 : SC + 2 * SS * k + 1);
        chk({tag, " pulses"}, rises, noop ? 0 : k);
        chk({tag, " high cycles"}, hi, noop ? 0 : SS * k);
        chk({tag, " first pulse"}, first, noop ? -1 : SC);
        chk({tag, " sel/dir unstable"}, bad, 0);
        chk({tag, " sel held"}, int'(pll_phasesel), m_sel);
        chk({tag, " dir held"}, int'(pll_phasedir), m_dir);
        chk_state(tag);
    endtask

    initial begin
        int n;
        for (int c = 0; c < CH; c++) m_phase[c] = 0;
        repeat (3) @(negedge clk);
        chk("reset pll_rst", int'(pll_rst), 1);
        chk("reset phasesel", int'(pll_phasesel), 0);
        chk("reset phasedir", int'(pll_phasedir), 0);
        chk("reset phasestep", int'(pll_phasestep), 0);
        chk("reset locked", int'(locked), 0);
        chk("reset req_ready", int'(req_ready), 0);
        chk_state("reset");

        // power-up: PLL locks as soon as its reset is released
        rstn = 1'b1;
        wait_for("powerup rst fall", 0, 1'b0, RC + 8, n);
        chk("powerup rst width", n, RC);
        pll_lock = 1'b1;
        wait_for("powerup lock", 1, 1'b1, LT, n);
        chk("powerup lock delay", n, LF + 2);
        chk("powerup ready", int'(req_ready), 1);
        chk_state("powerup");

        // directed requests, then randomized ones
        do_req(1, 0, 1);
        do_req(2, 1, 3);
        chk("wrap phase[2]", int'(phase[2*PW +: PW]), 29);
        do_req(2, 0, 5);
        chk("unwrap phase[2]", int'(phase[2*PW +: PW]), 2);
        do_req(0, 1, 0);
        do_req(3, 0, 4);
        do_req(0, 0, 255);
        for (int i = 0; i < 16; i++)
            do_req($urandom_range(0, 3), $urandom_range(0, 1),
                   $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 9));

        // lock loss during the 4th step pulse of a 10-step request
        req_valid = 1'b1; req_chan = 2'd0; req_dir = 1'b0; req_count = 8'd10;
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_for("lockloss step low", 3, 1'b0, 4 * SS, n);
            wait_for("lockloss step high", 3, 1'b1, 4 * SS, n);
        end
        pll_lock = 1'b0;
        wait_for("lockloss step drop", 3, 1'b0, 3, n);
        chk("lockloss within 3", int'(n <= 3), 1);
        chk("lockloss pll_rst", int'(pll_rst), 1);
        chk("lockloss locked", int'(locked), 0);
        chk("lockloss ready", int'(req_ready), 0);
        for (int c = 0; c < CH; c++) m_phase[c] = 0;
        m_sel = 0;
        m_dir = 0;
        chk_state("lockloss");

        // one-cycle lock glitch in WAIT_LOCK restarts the filter
        wait_for("glitch rst fall", 0, 1'b0, RC + 8, n);
        pll_lock = 1'b1;
        repeat (22) @(negedge clk);
        chk("glitch not yet locked", int'(locked), 0);
        pll_lock = 1'b0;
        @(negedge clk);
        pll_lock = 1'b1;
        wait_for("glitch relock", 1, 1'b1, LT, n);
        chk("glitch relock delay", n, LF + 2);
        do_req(1, 0, 2);
        do_req(0, 1, 1);

        // rstn mid-step drops phasestep without waiting for a clock edge
        req_valid = 1'b1; req_chan = 2'd1; req_dir = 1'b1; req_count = 8'd3;
        @(negedge clk);
        req_valid = 1'b0;
        wait_for("abort step high", 3, 1'b1, 4 * SS, n);
        #2 rstn = 1'b0;
        pll_lock = 1'b0;
        #1;
        chk("abort phasestep", int'(pll_phasestep), 0);
        chk("abort pll_rst", int'(pll_rst), 1);
        chk("abort locked", int'(locked), 0);
        chk("abort ready", int'(req_ready), 0);
        chk("abort phasesel", int'(pll_phasesel), 0);
        for (int c = 0; c < CH; c++) m_phase[c] = 0;
        m_retries = 0;
        chk_state("abort");
        @(negedge clk);
        rstn = 1'b1;

        // lock timeout: PLL never locks, reset retried and counted
        wait_for("tmo first fall", 0, 1'b0, RC + 8, n);
        chk("tmo first rst width", n, RC);
        for (int i = 0; i < 3; i++) begin
            wait_for("tmo rise", 0, 1'b1, LT + 8, n);
            chk($sformatf("tmo interval %0d", i), n, LT);
            m_retries++;
            chk($sformatf("tmo retries %0d", i), int'(retries), m_retries);
            wait_for("tmo fall", 0, 1'b0, RC + 8, n);
            chk($sformatf("tmo rst width %0d", i), n, RC);
        end
        repeat (257) begin
            wait_for("sat rise", 0, 1'b1, LT + 8, n);
            m_retries = m_retries < 255 ? m_retries + 1 : 255;
            wait_for("sat fall", 0, 1'b0, RC + 8, n);
        end
        chk("retries saturated", int'(retries), 255);
        chk_state("saturate");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ecp5pll_phase_sequencer.md
Name: ecp5pll_phase_sequencer

Overview:
- Supervises an ECP5 EHXPLLL clock generator and drives its dynamic phase-shift pins (PHASESEL, PHASEDIR, PHASESTEP, RST) from a request interface.
- Sits beside the PLL wrapper and runs on the free-running PLL input clock (e.g. 25 MHz).
- Adds what the static PLL wrappers lack: a PLL reset/lock sequencer with glitch filter and timeout retry, per-output runtime phase stepping, and per-output phase tracking for up to 4 outputs.

Parameters:
- CHANNELS, 4, number of PLL outputs controllable (1..4; index 0=CLKOP, 1=CLKOS, 2=CLKOS2, 3=CLKOS3).
- PHASE_MOD, 32, phase positions per output period; per-channel counter wraps modulo this value.
- RST_CYCLES, 16, cycles pll_rst held high per reset attempt.
- LOCK_FILTER, 1024, consecutive synchronized-lock-high cycles required before locked is declared.
- LOCK_TIMEOUT, 65536, cycles allowed in WAIT_LOCK before another reset attempt.
- SETUP_CYCLES, 2, cycles phasesel/phasedir are stable before each phasestep pulse.
- STEP_CYCLES, 4, phasestep high cycles, and also low cycles after each pulse.

Ports:
- clk  in  1  free-running reference clock (PLL input clock).
- rstn  in  1  asynchronous active-low reset.
- pll_lock  in  1  PLL LOCK output (asynchronous to clk).
- pll_rst  out  1  to EHXPLLL RST.
- pll_phasesel  out  2  to PHASESEL1:0.
- pll_phasedir  out  1  to PHASEDIR (0=delay/+1, 1=advance/-1).
- pll_phasestep  out  1  to PHASESTEP.
- locked  out  1  filtered lock status.
- req_valid  in  1  phase-shift request valid.
- req_ready  out  1  request accepted when valid&ready.
- req_chan  in  2  target channel.
- req_dir  in  1  direction, same encoding as pll_phasedir.
- req_count  in  8  number of steps; 0 is a legal no-op.
- phase  out  CHANNELS*PHASE_W  per-channel phase, PHASE_W=clog2(PHASE_MOD); channel n at bits [n*PHASE_W +: PHASE_W].
- retries  out  8  saturating count of timeout-triggered PLL resets.

Behaviour:
- Reset values (rstn low): pll_rst=1, pll_phasesel=0, pll_phasedir=0, pll_phasestep=0, locked=0, req_ready=0, phase=all 0, retries=0; state RESET_PLL with cycle counter 0.
- pll_lock passes through a 2-flop synchronizer; lock_s denotes the synchronized value (2-cycle latency).
- RESET_PLL: pll_rst=1 for RST_CYCLES cycles, then go to WAIT_LOCK with pll_rst=0. Entry always clears every phase counter to 0, because PLL reset restores static phases.
- WAIT_LOCK:
  - Filter counter increments while lock_s=1 and clears to 0 on any lock_s=0.
  - When it reaches LOCK_FILTER, go to IDLE and set locked=1 on the same edge.
  - A timeout counter runs from entry. When it reaches LOCK_TIMEOUT, go to RESET_PLL and increment retries (saturating at 255).
- IDLE:
  - req_ready=1 only in IDLE with locked=1.
  - On handshake, latch chan/dir/count.
  - count=0: stay in IDLE, no pulse, phase unchanged, req_ready stays 1.
  - count>0: go to SETUP with req_ready=0.
- SETUP: drive pll_phasesel=chan and pll_phasedir=dir for SETUP_CYCLES cycles, then go to STEP_HI.
- STEP_HI: pll_phasestep=1 for STEP_CYCLES cycles, then go to STEP_LO.
- STEP_LO:
  - pll_phasestep=0 for STEP_CYCLES cycles. On the last cycle, update phase[chan] (dir 0: +1 mod PHASE_MOD; dir 1: -1 mod PHASE_MOD, so 0-1 wraps to PHASE_MOD-1) and decrement the remaining count.
  - If the remaining count is nonzero, go back to STEP_HI; phasesel/dir are unchanged, so no re-setup is needed.
  - Otherwise return to IDLE, with req_ready=1 on the next cycle.
- Per-step period: 2*STEP_CYCLES. Total request latency from handshake to req_ready: SETUP_CYCLES + count*2*STEP_CYCLES + 1 cycles.
- pll_phasesel and pll_phasedir hold their last values in IDLE; they only change in SETUP.
- req_chan >= CHANNELS: the handshake completes as a no-op (same as count=0).
- Lock loss: lock_s=0 in IDLE, SETUP, STEP_HI or STEP_LO causes, on the next edge:
  - locked=0, req_ready=0, pll_phasestep=0;
  - the in-flight request is aborted and the remaining steps discarded;
  - state goes to RESET_PLL, which clears the phase counters;
  - retries is not incremented (only timeouts count).
- rstn asserted mid-operation: immediate return to reset values; pll_phasestep drops asynchronously.

Test Plan:
- Power-up: rstn released, pll_lock held 1 -> pll_rst high exactly 16 cycles; locked rises 2+1024 cycles after pll_rst falls; req_ready=1 after that; retries=0.
- Glitch filter: in WAIT_LOCK, pll_lock low for 1 cycle at filter count 1000 -> filter restarts; locked rises 1024 cycles after lock_s returns to 1.
- Single step: req chan=1, dir=0, count=1 -> phasesel=1 for 2 cycles; one phasestep pulse 4 cycles wide; phase[1]=1; req_ready back after 11 cycles.
- Wrap and multi-step: chan=2, dir=1, count=3 from phase 0 -> three pulses 8 cycles apart; phase[2]=29. Then dir=0, count=5 -> phase[2]=2.
- Lock loss mid-request: count=10, drop pll_lock during the 4th STEP_HI -> phasestep low within 3 cycles of the drop; pll_rst=1; all phases 0; locked=0; retries unchanged.
- Timeout: pll_lock held 0 -> pll_rst re-pulses every 16+65536 cycles; retries counts 1,2,3; after forced 255+ attempts it stays at 255.
